inside_set_writer: RTL and testbench
====================================

// Module: inside_set_writer
// PURPOSE
// - Write side of the value-set membership table: maintains up to DEPTH unique WIDTH-bit values.
// - Accepts insert/delete commands over a valid/ready handshake.
// - Uses a sequential scan for duplicate and not-found detection; returns one status response per command.
// - Exposes the stored set through a combinational read port, which the membership-lookup block uses as its values table.
// PARAMETERS
// - WIDTH  8  bit width of each stored value
// - DEPTH  4  number of table entries (power of two, >=2)
// - IDXW   2  index width, must equal $clog2(DEPTH)
// PORTS
// - clk         in   1        single clock, rising edge
// - rst         in   1        synchronous, active-high reset
// - cmd_valid   in   1        command present
// - cmd_ready   out  1        block can accept a command
// - cmd_op      in   1        0 = insert, 1 = delete
// - cmd_data    in   WIDTH    value to insert or delete
// - rsp_valid   out  1        one-cycle response strobe
// - rsp_status  out  2        00 OK, 01 DUP (insert) / NOTFOUND (delete), 10 FULL, 11 unused
// - rsp_index   out  IDXW     slot written, matched or cleared; 0 on FULL or NOTFOUND
// - rd_idx      in   IDXW     table read address
// - rd_data     out  WIDTH    value at rd_idx (0 if slot empty), combinational
// - rd_vld      out  1        slot rd_idx holds a valid value, combinational
// - count       out  IDXW+1   number of valid entries, 0..DEPTH
// BEHAVIOUR
// - Reset (sync on rst=1):
//   - all slots cleared: data=0, valid=0; count=0.
//   - FSM goes to IDLE; cmd_ready=1; rsp_valid=0, rsp_status=00, rsp_index=0.
// - FSM states IDLE -> SCAN -> RESP -> IDLE.
// - IDLE:
//   - cmd_ready=1.
//   - On cmd_valid&cmd_ready: latch cmd_op and cmd_data, set scan pointer to 0, go to SCAN.
// - SCAN:
//   - cmd_ready=0. Visits exactly one slot per cycle, slot 0 up to DEPTH-1. Always DEPTH cycles, no early exit.
//   - Match = slot valid and slot data == latched value; record the matching index.
//   - Record the lowest-index empty slot seen.
//   - After slot DEPTH-1, go to RESP.
// - RESP: rsp_valid=1 for exactly this cycle; cmd_ready=0.
//   - insert, match: status 01, index = match; table unchanged.
//   - insert, no match, no free slot: status 10, index 0; table unchanged.
//   - insert, no match, free slot: write value to lowest free slot, set valid, count+1; status 00, index = slot.
//   - delete, match: clear slot (data=0, valid=0), count-1; status 00, index = slot.
//   - delete, no match: status 01, index 0.
//   - Table and count updates become visible on rd_* and count the cycle after RESP.
// - Latency: command accepted at edge N -> rsp_valid high in cycle N+DEPTH+1 -> cmd_ready high again in the following cycle.
//   - Throughput: 1 command per DEPTH+2 cycles.
// - Invariants:
//   - No duplicate values are ever stored, so at most one match exists.
//   - count always equals the number of set valid bits.
// - cmd_data and cmd_op are ignored while cmd_ready=0; a held cmd_valid is accepted on return to IDLE.
// - rst asserted mid-SCAN or in RESP:
//   - in-flight command is dropped with no response;
//   - the table is cleared even if a write was pending.
// - rsp_status and rsp_index hold their last values between strobes.
// CONFIGURATION
// - INSIDE_SET_PRELOAD_EN defined:
//   - reset loads slot k with 100+10*k for k<4 (slots >=4 empty); valid=1 for those slots; count=min(DEPTH,4).
//   - At DEPTH=4: 100, 110, 120, 130, count=4.
// - INSIDE_SET_PRELOAD_EN undefined: reset leaves the table empty as above. No other behaviour changes.
// TESTING (WIDTH=8, DEPTH=4, macro undefined unless noted)
// - Insert 100 after reset -> rsp_valid exactly 5 cycles after accept; status 00, index 0; count 1; rd_idx=0 gives 100, rd_vld=1.
// - Insert 100 again -> status 01, index 0; count stays 1. Then insert 110,120,130 -> OK at indices 1,2,3; insert 140 -> status 10, count 4.
// - Delete 120 -> status 00, index 2; count 3; rd_idx=2 gives 0, rd_vld=0. Insert 140 -> OK at index 2. Delete 55 -> status 01, index 0.
// - cmd_valid held high continuously with 4 distinct inserts -> accepts spaced 6 cycles apart; cmd_ready low for the entire SCAN and RESP.
// - rst pulsed during the 2nd SCAN cycle of an insert of 77 -> no rsp_valid; count 0; all rd_vld 0; next command accepted the cycle after rst drops.
// - INSIDE_SET_PRELOAD_EN defined, reset -> count 4, rd_data 100/110/120/130; insert 110 -> status 01, index 1; insert 5 -> status 10.

Source files
------------

// File: rtl/inside_set_writer.sv
// Write side of the value-set membership table: insert/delete with a sequential scan.
// Optional reset preload of the table is enabled by defining INSIDE_SET_PRELOAD_EN.
module inside_set_writer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [1:0]       rsp_status,
    output logic [IDXW-1:0]  rsp_index,
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld,
    output logic [IDXW:0]    count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_MISS = 2'b01;
    localparam logic [1:0] ST_FULL = 2'b10;

    localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);
    localparam logic [IDXW:0] PRE_CNT = (IDXW+1)'((DEPTH < 4) ? DEPTH : 4);

    logic [1:0]       state_q, state_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic             mf_q, mf_d;
    logic [IDXW-1:0]  mi_q, mi_d;
    logic             ff_q, ff_d;
    logic [IDXW-1:0]  fi_q, fi_d;
    logic [1:0]       rsp_status_q, rsp_status_d;
    logic [IDXW-1:0]  rsp_index_q, rsp_index_d;
    logic [IDXW:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic             hit;
    logic             empty;

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_status = rsp_status_q;
    assign rsp_index  = rsp_index_q;
    assign count      = count_q;
    assign rd_vld     = vld_q[rd_idx];
    assign rd_data    = vld_q[rd_idx] ? data_q[rd_idx] : '0;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        val_d        = val_q;
        ptr_d        = ptr_q;
        mf_d         = mf_q;
        mi_d         = mi_q;
        ff_d         = ff_q;
        fi_d         = fi_q;
        rsp_status_d = rsp_status_q;
        rsp_index_d  = rsp_index_q;
        count_d      = count_q;
        data_d       = data_q;
        vld_d        = vld_q;
        hit          = 1'b0;
        empty        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    val_d   = cmd_data;
                    ptr_d   = '0;
                    mf_d    = 1'b0;
                    mi_d    = '0;
                    ff_d    = 1'b0;
                    fi_d    = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                hit   = vld_q[ptr_q] && (data_q[ptr_q] == val_q);
                empty = !vld_q[ptr_q];
                mf_d  = mf_q | hit;
                mi_d  = hit ? ptr_q : mi_q;
                ff_d  = ff_q | empty;
                fi_d  = (!ff_q && empty) ? ptr_q : fi_q;
                ptr_d = ptr_q + 1'b1;
                // The response is decided on the last slot so it is ready in RESP
                if (ptr_q == LAST) begin
                    state_d = S_RESP;
                    if (!op_q) begin
                        if (mf_d) begin
                            rsp_status_d = ST_MISS;
                            rsp_index_d  = mi_d;
                        end else if (!ff_d) begin
                            rsp_status_d = ST_FULL;
                            rsp_index_d  = '0;
                        end else begin
                            rsp_status_d = ST_OK;
                            rsp_index_d  = fi_d;
                        end
                    end else begin
                        rsp_status_d = mf_d ? ST_OK : ST_MISS;
                        rsp_index_d  = mf_d ? mi_d : '0;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (!op_q && !mf_q && ff_q) begin
                    data_d[fi_q] = val_q;
                    vld_d[fi_q]  = 1'b1;
                    count_d      = count_q + (IDXW+1)'(1);
                end else if (op_q && mf_q) begin
                    data_d[mi_q] = '0;
                    vld_d[mi_q]  = 1'b0;
                    count_d      = count_q - (IDXW+1)'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 1'b0;
            val_q        <= '0;
            ptr_q        <= '0;
            mf_q         <= 1'b0;
            mi_q         <= '0;
            ff_q         <= 1'b0;
            fi_q         <= '0;
            rsp_status_q <= ST_OK;
            rsp_index_q  <= '0;
`ifdef INSIDE_SET_PRELOAD_EN
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= (k < 4) ? WIDTH'(100 + 10 * k) : '0;
                vld_q[k]  <= (k < 4);
            end
            count_q <= PRE_CNT;
`else
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                vld_q[k]  <= 1'b0;
            end
            count_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            val_q        <= val_d;
            ptr_q        <= ptr_d;
            mf_q         <= mf_d;
            mi_q         <= mi_d;
            ff_q         <= ff_d;
            fi_q         <= fi_d;
            rsp_status_q <= rsp_status_d;
            rsp_index_q  <= rsp_index_d;
            count_q      <= count_d;
            vld_q        <= vld_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

endmodule

// File: tb/tb_inside_set_writer.sv
// Randomized and directed bench for inside_set_writer against a set model.
// Honours INSIDE_SET_PRELOAD_EN for the model's reset contents.
module tb_inside_set_writer;

    localparam int DEPTH = 4;
    localparam int LAT   = DEPTH + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic [1:0] rsp_index;
    logic [1:0] rd_idx = '0;
    logic [7:0] rd_data;
    logic       rd_vld;
    logic [2:0] count;

    inside_set_writer #(.WIDTH(8), .DEPTH(4), .IDXW(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .rsp_index(rsp_index),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_vld(rd_vld),
        .count(count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: a plain array of values with valid flags
    logic [7:0] m_data [DEPTH];
    bit         m_vld  [DEPTH];
    int         busy = 0;
    bit         started = 0;
    bit         p_op;
    logic [7:0] p_data;
    logic [1:0] p_status, last_status;
    logic [1:0] p_index, last_index;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_vld[i]) n++;
        return n;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) begin
`ifdef INSIDE_SET_PRELOAD_EN
            m_data[i] = 8'(100 + 10 * i);
            m_vld[i]  = 1'b1;
`else
            m_data[i] = '0;
            m_vld[i]  = 1'b0;
`endif
        end
        busy = 0;
        last_status = 2'b00;
        last_index  = 2'b00;
    endfunction

    function automatic void m_accept(bit op, logic [7:0] d);
        int found = -1;
        int free = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && m_data[i] == d) found = i;
            if (!m_vld[i] && free < 0) free = i;
        end
        p_op = op;
        p_data = d;
        if (!op) begin
            if (found >= 0) begin p_status = 2'b01; p_index = 2'(found); end
            else if (free < 0) begin p_status = 2'b10; p_index = 2'b00; end
            else begin p_status = 2'b00; p_index = 2'(free); end
        end else begin
            if (found >= 0) begin p_status = 2'b00; p_index = 2'(found); end
            else begin p_status = 2'b01; p_index = 2'b00; end
        end
    endfunction

    function automatic void m_commit();
        if (p_status == 2'b00) begin
            m_data[p_index] = p_op ? 8'd0 : p_data;
            m_vld[p_index]  = !p_op;
        end
        last_status = p_status;
        last_index  = p_index;
    endfunction

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        if (rst) m_reset();
        else if (busy == LAT) begin m_commit(); busy = 0; end
        else if (busy > 0) busy++;
        else if (cmd_valid) begin m_accept(cmd_op, cmd_data); busy = 1; end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(busy == 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(busy == LAT));
            if (busy == LAT) begin
                chk("rsp_status", 32'(rsp_status), 32'(p_status));
                chk("rsp_index", 32'(rsp_index), 32'(p_index));
            end else begin
                chk("rsp_status_hold", 32'(rsp_status), 32'(last_status));
                chk("rsp_index_hold", 32'(rsp_index), 32'(last_index));
            end
            chk("count", 32'(count), 32'(m_count()));
            chk("rd_vld", 32'(rd_vld), 32'(m_vld[rd_idx]));
            chk("rd_data", 32'(rd_data), 32'(m_vld[rd_idx] ? m_data[rd_idx] : 8'd0));
            rd_idx = 2'($urandom_range(0, 3));
        end
    end

    task automatic do_cmd(bit op, logic [7:0] d, bit lit, logic [1:0] es, logic [1:0] ei);
        int w = 0;
        int lat = 1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        chk("accept_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 1'($urandom);
        cmd_data = 8'($urandom);
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("latency", 32'(lat), 32'(LAT));
        if (lit) begin
            chk("lit_status", 32'(rsp_status), 32'(es));
            chk("lit_index", 32'(rsp_index), 32'(ei));
        end
    endtask

    task automatic peek(logic [1:0] idx, bit ev, logic [7:0] ed, int ec);
        @(posedge clk);
        #1 rd_idx = idx;
        #1;
        chk("lit_rd_vld", 32'(rd_vld), 32'(ev));
        chk("lit_rd_data", 32'(rd_data), 32'(ed));
        chk("lit_count", 32'(count), 32'(ec));
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    logic [7:0] pool [6];
    int acc [4];

    initial begin
        pool = '{8'd3, 8'd17, 8'd42, 8'd99, 8'd200, 8'd255};
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef INSIDE_SET_PRELOAD_EN
        chk("lit_rst_count", 32'(count), 32'd4);
        peek(2'd3, 1'b1, 8'd130, 4);
        do_cmd(1'b0, 8'd110, 1'b1, 2'b01, 2'd1);
        do_cmd(1'b0, 8'd5, 1'b1, 2'b10, 2'd0);
        peek(2'd0, 1'b1, 8'd100, 4);
`else
        chk("lit_rst_count", 32'(count), 32'd0);
        chk("lit_rst_ready", 32'(cmd_ready), 32'd1);
        chk("lit_rst_status", 32'(rsp_status), 32'd0);
        do_cmd(1'b0, 8'd100, 1'b1, 2'b00, 2'd0);
        peek(2'd0, 1'b1, 8'd100, 1);
        do_cmd(1'b0, 8'd100, 1'b1, 2'b01, 2'd0);
        peek(2'd0, 1'b1, 8'd100, 1);
        do_cmd(1'b0, 8'd110, 1'b1, 2'b00, 2'd1);
        do_cmd(1'b0, 8'd120, 1'b1, 2'b00, 2'd2);
        do_cmd(1'b0, 8'd130, 1'b1, 2'b00, 2'd3);
        do_cmd(1'b0, 8'd140, 1'b1, 2'b10, 2'd0);
        peek(2'd3, 1'b1, 8'd130, 4);
        do_cmd(1'b1, 8'd120, 1'b1, 2'b00, 2'd2);
        peek(2'd2, 1'b0, 8'd0, 3);
        do_cmd(1'b0, 8'd140, 1'b1, 2'b00, 2'd2);
        peek(2'd2, 1'b1, 8'd140, 4);
        do_cmd(1'b1, 8'd55, 1'b1, 2'b01, 2'd0);
`endif
        // Reset during the second scan cycle of an insert of 77
        pulse_rst();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 8'd77;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        cmd_valid = 1'b1; cmd_data = 8'd9;
        chk("lit_rst_mid_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        chk("lit_rst_mid_taken", 32'(cmd_ready), 32'd0);
        repeat (LAT + 1) @(negedge clk);
        pulse_rst();
        // Held cmd_valid: accepts must be DEPTH+2 cycles apart
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 8'd11;
        for (int k = 0; k < 4; k++) begin
            int w = 0;
            while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
            acc[k] = cyc;
            @(posedge clk);
            @(negedge clk);
            cmd_data = 8'(12 + k);
        end
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) chk("held_spacing", 32'(acc[k+1] - acc[k]), 32'(DEPTH + 2));
        repeat (LAT + 1) @(negedge clk);
        // Random traffic over a small value pool to hit dup, full and not-found
        for (int n = 0; n < 120; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_cmd(($urandom_range(0, 2) == 0), pool[$urandom_range(0, 5)], 1'b0, 2'b00, 2'b00);
            if ($urandom_range(0, 40) == 0) pulse_rst();
        end
        repeat (LAT + 2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
